// File: rtl/bitwise_serial_unit_if.sv
// Operand/result handshake bundle for bitwise_serial_unit.
// master = sequencer side, slave = the serial unit.
// BWSU_SIGNED_EN adds the sgn (two's-complement compare) request bit.
interface bitwise_serial_unit_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] q;
   logic             flag;
`ifdef BWSU_SIGNED_EN
   logic             sgn;

   modport master (output in_valid, op, a, b, sgn, out_ready,
                   input  in_ready, out_valid, q, flag);
   modport slave  (input  in_valid, op, a, b, sgn, out_ready,
                   output in_ready, out_valid, q, flag);
`else
   modport master (output in_valid, op, a, b, out_ready,
                   input  in_ready, out_valid, q, flag);
   modport slave  (input  in_valid, op, a, b, out_ready,
                   output in_ready, out_valid, q, flag);
`endif
endinterface

// File: rtl/bitwise_serial_unit.sv
// Serial bitwise / compare unit: WIDTH-bit operands are processed SLICE bits
// per clock, LSB slice first, with the ne/gt compare chains carried across
// cycles in flag registers.
// Optional: define BWSU_SIGNED_EN to add the sgn input (two's-complement a > b).
module bitwise_serial_unit #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input logic                 clk,
   input logic                 rst,
   bitwise_serial_unit_if.slave bus
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH % SLICE != 0) begin : g_bad_slice
         $error("bitwise_serial_unit: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic             in_ready, out_valid, accept, last, signed_msb;
   logic [CW-1:0]    count;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] a_r, b_r, q_r, q_nx;
   logic             ne, gt, flag_r;
   logic             ne_nx, gt_nx, raw_nx, flag_nx;
   logic [SLICE-1:0] a_sl, b_sl, q_sl;
   int               sh;
`ifdef BWSU_SIGNED_EN
   logic             sgn_r;
`endif

   assign accept        = bus.in_valid & in_ready;
   assign last          = (count == CW'(N - 1));
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.q         = q_r;
   assign bus.flag      = flag_r;

`ifdef BWSU_SIGNED_EN
   // Signed compare only reinterprets the very top bit of the operand.
   assign signed_msb = sgn_r & op_r[1] & last;
`else
   assign signed_msb = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and handshake outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Current slice: bitwise result and compare chains, LSB to MSB
   always_comb begin
      sh    = int'(count) * SLICE;
      a_sl  = SLICE'(a_r >> sh);
      b_sl  = SLICE'(b_r >> sh);
      ne_nx = ne;
      gt_nx = gt;
      for (int i = 0; i < SLICE; i++) begin
         ne_nx = ne_nx | (a_sl[i] ^ b_sl[i]);
         if (signed_msb && i == SLICE - 1)
            gt_nx = (~a_sl[i] & b_sl[i]) | (~(a_sl[i] ^ b_sl[i]) & gt_nx);
         else
            gt_nx = (a_sl[i] & ~b_sl[i]) | (~(a_sl[i] ^ b_sl[i]) & gt_nx);
      end
      case (op_r)
         2'b00:   q_sl = '0;
         2'b01:   q_sl = a_sl ^ b_sl;
         2'b10:   q_sl = a_sl & b_sl;
         default: q_sl = a_sl | b_sl;
      endcase
      q_nx    = (q_r & ~(WIDTH'({SLICE{1'b1}}) << sh)) | (WIDTH'(q_sl) << sh);
      raw_nx  = op_r[1] ? gt_nx : ne_nx;
      flag_nx = op_r[0] ? ~raw_nx : raw_nx;
   end

   // Operand latch on accept; q/flag/chains advance only while running
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= '0;
         op_r   <= 2'b00;
         a_r    <= '0;
         b_r    <= '0;
         q_r    <= '0;
         ne     <= 1'b0;
         gt     <= 1'b0;
         flag_r <= 1'b0;
`ifdef BWSU_SIGNED_EN
         sgn_r  <= 1'b0;
`endif
      end else if (accept) begin
         count  <= '0;
         op_r   <= bus.op;
         a_r    <= bus.a;
         b_r    <= bus.b;
         ne     <= 1'b0;
         gt     <= 1'b0;
`ifdef BWSU_SIGNED_EN
         sgn_r  <= bus.sgn;
`endif
      end else if (state == RUN) begin
         q_r    <= q_nx;
         ne     <= ne_nx;
         gt     <= gt_nx;
         flag_r <= flag_nx;
         count  <= count + 1'b1;
      end
   end
endmodule

// File: tb/tb_bitwise_serial_unit.sv
// Randomised self-checking bench: a 4-bit-slice unit and a single-pass
// (SLICE == WIDTH) unit share one stimulus driver, selected by sel.
module tb_bitwise_serial_unit;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bitwise_serial_unit_if #(.WIDTH(W)) bus0 ();
   bitwise_serial_unit_if #(.WIDTH(W)) bus1 ();

   bitwise_serial_unit #(.WIDTH(W), .SLICE(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
   bitwise_serial_unit #(.WIDTH(W), .SLICE(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   logic         sel, iv, ordy, sg;
   logic [1:0]   op;
   logic [W-1:0] a, b;

   assign bus0.in_valid  = iv & ~sel;
   assign bus1.in_valid  = iv & sel;
   assign bus0.out_ready = ordy & ~sel;
   assign bus1.out_ready = ordy & sel;
   assign bus0.op = op;  assign bus1.op = op;
   assign bus0.a  = a;   assign bus1.a  = a;
   assign bus0.b  = b;   assign bus1.b  = b;
`ifdef BWSU_SIGNED_EN
   assign bus0.sgn = sg; assign bus1.sgn = sg;
`endif

   wire         ov = sel ? bus1.out_valid : bus0.out_valid;
   wire         ir = sel ? bus1.in_ready  : bus0.in_ready;
   wire [W-1:0] qo = sel ? bus1.q         : bus0.q;
   wire         fo = sel ? bus1.flag      : bus0.flag;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: whole-word arithmetic straight from the op table
   function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, output logic [W-1:0] qq, output logic ff);
      logic gtv, raw;
      case (o)
         2'b00:   qq = '0;
         2'b01:   qq = x ^ y;
         2'b10:   qq = x & y;
         default: qq = x | y;
      endcase
      if (s) gtv = $signed(x) > $signed(y);
      else   gtv = x > y;
      raw = o[1] ? gtv : (x != y);
      ff  = o[0] ? ~raw : raw;
   endfunction

   // One complete transaction; lat counts edges with the accepting edge as 1
   task automatic run_op(input logic s_i, input logic [1:0] op_i, input logic [W-1:0] a_i,
                         input logic [W-1:0] b_i, input logic sg_i, input int hold, input int exp_lat);
      logic [W-1:0] eq;
      logic         ef, seff;
      int           lat;
`ifdef BWSU_SIGNED_EN
      seff = sg_i;
`else
      seff = 1'b0;
`endif
      model(op_i, a_i, b_i, seff, eq, ef);
      @(negedge clk);
      sel = s_i; op = op_i; a = a_i; b = b_i; sg = sg_i; iv = 1'b1; ordy = 1'b0;
      chk("in_ready_idle", ir, 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      // Everything here must be ignored while the operation runs
      a = W'($urandom); b = W'($urandom); op = 2'($urandom); sg = 1'($urandom);
      while (!ov && lat < 40) begin
         chk("in_ready_run", ir, 0);
         iv = 1'($urandom); ordy = 1'($urandom);
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      ordy = 1'b0;
      iv   = 1'b0;
      chk("latency", lat, exp_lat);
      chk("q", qo, eq);
      chk("flag", fo, ef);
      chk("in_ready_done", ir, 0);
      for (int h = 0; h < hold; h++) begin
         iv = 1'b1; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("bp_valid", ov, 1);
         chk("bp_ready", ir, 0);
         chk("bp_q", qo, eq);
         chk("bp_flag", fo, ef);
      end
      iv = 1'b0; ordy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ordy = 1'b0;
      chk("rel_valid", ov, 0);
      chk("rel_ready", ir, 1);
   endtask

   initial begin
      int vcnt;
      logic [W-1:0] ra, rb;
      rst = 1'b1; iv = 1'b0; ordy = 1'b0; sel = 1'b0; sg = 1'b0;
      op = 2'b00; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_valid", ov, 0);
         chk("rst_ready", ir, 1);
         chk("rst_q", qo, 0);
         chk("rst_flag", fo, 0);
      end
      sel = 1'b0;
      rst = 1'b0;

      // Directed cases, 4-bit slices
      run_op(1'b0, 2'b10, 16'hF0F0, 16'hFF00, 1'b0, 6, 5);
      run_op(1'b0, 2'b01, 16'h1234, 16'h1234, 1'b0, 0, 5);
      run_op(1'b0, 2'b00, 16'h0001, 16'h8001, 1'b0, 0, 5);
      run_op(1'b0, 2'b11, 16'h8000, 16'h7FFF, 1'b0, 1, 5);
      run_op(1'b0, 2'b11, 16'h8000, 16'h7FFF, 1'b1, 0, 5);
      run_op(1'b0, 2'b11, 16'h0010, 16'h0001, 1'b0, 0, 5);
      run_op(1'b0, 2'b10, 16'hFFFF, 16'hFFFF, 1'b1, 0, 5);
      // Single-pass unit
      run_op(1'b1, 2'b11, 16'h0010, 16'h0001, 1'b0, 0, 2);
      run_op(1'b1, 2'b10, 16'hF0F0, 16'hFF00, 1'b0, 2, 2);

      // Reset while running with count = 2
      @(negedge clk);
      sel = 1'b0; op = 2'b01; a = 16'hAAAA; b = 16'h5555; iv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", ov, 0);
      chk("abort_ready", ir, 1);
      chk("abort_q", qo, 0);
      chk("abort_flag", fo, 0);
      vcnt = 0;
      repeat (8) begin
         @(posedge clk);
         @(negedge clk);
         if (ov) vcnt++;
      end
      chk("abort_no_valid", vcnt, 0);
      run_op(1'b0, 2'b10, 16'h1357, 16'h1356, 1'b0, 0, 5);

      // Random traffic on both units
      for (int k = 0; k < 60; k++) begin
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
         run_op(1'(k % 4 == 3), 2'($urandom), ra, rb, 1'($urandom),
                $urandom_range(0, 3), (k % 4 == 3) ? 2 : 5);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
